pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 64, width of the data payload.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 in_valid  input  1  upstream presents in_data this cycle.
REQ-005 in_data  input  DATA_W  upstream payload.
REQ-006 in_ready  output  1  block accepts in_data this cycle; registered.
REQ-007 out_valid  output  1  out_data holds a valid word; registered.
REQ-008 out_data  output  DATA_W  head word to downstream; registered.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 flush  input  1  synchronous discard of all held words; present only with PIPE_SKID_FLUSH_EN (REQ-027).

Function
REQ-011 push = in_valid & in_ready; pop = out_valid & out_ready; a transfer occurs only on a posedge with push or pop true.
REQ-012 Storage: main register (drives out_data) plus one skid register; capacity 2 words.
REQ-013 States: EMPTY (0 words), BUSY (main only), FULL (main + skid).
REQ-014 EMPTY: push -> BUSY, main <= in_data; else stay.
REQ-015 BUSY: push & ~pop -> FULL, skid <= in_data; pop & ~push -> EMPTY; push & pop -> BUSY, main <= in_data; neither -> stay.
REQ-016 FULL: pop -> BUSY, main <= skid; no push possible (in_ready = 0); neither -> stay.
REQ-017 out_valid = 1 exactly when the state is BUSY or FULL; in_ready = 1 exactly when the state is EMPTY or BUSY, out of reset (REQ-022).
REQ-018 Latency: a word pushed on edge N appears on out_data with out_valid = 1 after edge N when the block was EMPTY.
REQ-019 Throughput: one word per cycle sustained when in_valid and out_ready stay high.
REQ-020 Order: words leave in push order; none dropped or duplicated; out_data holds steady while out_valid & ~out_ready.
REQ-021 in_data is ignored whenever push is false; X on in_data with in_valid = 0 does not propagate.

Reset
REQ-022 While reset = 0: state = EMPTY, out_valid = 0, in_ready = 0, out_data = 0, skid = 0.
REQ-023 in_ready rises to 1 on the first posedge after reset deasserts; no push is accepted before that edge.
REQ-024 Reset asserted mid-operation discards both held words; no partial transfer completes on that edge.

Configuration
REQ-025 Macro PIPE_SKID_FLUSH_EN selects the flush feature.
REQ-026 Without the macro: no flush port; behaviour is REQ-011..REQ-024 only.
REQ-027 With the macro: flush = 1 at a posedge forces state EMPTY, out_valid = 0, in_ready = 1 after the edge; a coincident push or pop is void; data registers keep their values; flush has priority over all transitions; reset has priority over flush.

Structure
REQ-028 Shared package pipe_skid_pkg holds the DATA_W default constant and the state enum typedef (EMPTY, BUSY, FULL).
REQ-029 One sub-module, skid_entry: a DATA_W-wide load-enabled register with async active-low clear, instantiated twice (main, skid).
REQ-030 The state register and the in_ready/out_valid flops live in pipe_skid_reg.

Verification
REQ-031 Reset pulse, then in_valid = 1, in_data = 0x1, out_ready = 1 -> in_ready = 1 after the first edge; out_data = 0x1, out_valid = 1 one edge after push.
REQ-032 out_ready = 0, push 0xA then 0xB -> state FULL, in_ready = 0, out_data = 0xA; third word 0xC is held off; out_ready = 1 -> 0xA, 0xB, 0xC pop in order.
REQ-033 in_valid = 1, out_ready = 1 for 10 cycles with in_data = 0..9 -> out_data = 0..9 on consecutive cycles, no bubbles.
REQ-034 FULL with 0x5, 0x6, then reset = 0 between edges -> out_valid = 0 and in_ready = 0 immediately; after release, first pop is a newly pushed word, never 0x5 or 0x6.
REQ-035 (PIPE_SKID_FLUSH_EN) FULL, flush = 1 with out_ready = 1 and in_valid = 1 -> next cycle EMPTY, out_valid = 0, in_ready = 1, no word delivered or accepted on that edge.
REQ-036 Random in_valid/out_ready for 1000 cycles against a scoreboard queue -> zero order or count mismatches; out_data stable whenever out_valid & ~out_ready.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// Shared definitions for the pipe_skid_reg two-entry skid buffer.
// Configuration macro used by the slice: PIPE_SKID_FLUSH_EN.
package pipe_skid_pkg;

    localparam int unsigned PIPE_SKID_DATA_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_reg_skid_entry.sv
// Load-enabled data register with asynchronous active-low clear.
// One storage slot of pipe_skid_reg (main or skid word).
module skid_entry
    import pipe_skid_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_SKID_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry registered skid buffer (main + skid word) with valid/ready handshake.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
    import pipe_skid_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_SKID_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic              push;
    logic              pop;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (push && !pop) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop && !push) begin
                    state_d   = EMPTY;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush voids any coincident transfer; stored words are left untouched.
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
`endif
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    // Handshake flops track the next state so both stay registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    skid_entry #(
        .DATA_W (DATA_W)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (load_main),
        .d     (main_d),
        .q     (out_data)
    );

    skid_entry #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized self-checking bench for pipe_skid_reg.
// Flush steps are included when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
`ifdef PIPE_SKID_FLUSH_EN
    logic        flush;
`endif

    int unsigned checks;
    int unsigned failures;

    logic [63:0] q[$];
    logic [63:0] prev_data;
    logic        prev_hold;
    logic        m_push;
    logic        m_pop;

    pipe_skid_reg #(
        .DATA_W (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset state, before and after edges with reset held
        #3;
        chk("rst_valid0", {63'd0, out_valid}, 64'd0);
        chk("rst_ready0", {63'd0, in_ready}, 64'd0);
        chk("rst_data0", out_data, 64'd0);
        tick();
        tick();
        chk("rst_valid1", {63'd0, out_valid}, 64'd0);
        chk("rst_ready1", {63'd0, in_ready}, 64'd0);

        // First push after reset release
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        out_ready = 1'b1;
        tick();
        chk("first_ready", {63'd0, in_ready}, 64'd1);
        chk("first_novalid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("first_valid", {63'd0, out_valid}, 64'd1);
        chk("first_data", out_data, 64'h1);
        in_valid = 1'b0;
        tick();
        chk("first_drain", {63'd0, out_valid}, 64'd0);
        chk("first_ready2", {63'd0, in_ready}, 64'd1);

        // Fill to FULL with back-pressure, hold off third word, drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        chk("fill_a", out_data, 64'hA);
        in_data = 64'hB;
        tick();
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        chk("full_data", out_data, 64'hA);
        in_data = 64'hC;
        tick();
        chk("full_hold_ready", {63'd0, in_ready}, 64'd0);
        chk("full_hold_data", out_data, 64'hA);
        out_ready = 1'b1;
        tick();
        chk("drain_b", out_data, 64'hB);
        chk("drain_b_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("drain_c", out_data, 64'hC);
        chk("drain_c_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // Sustained throughput, one word per cycle
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 64'(i);
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_data", out_data, 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", {63'd0, out_valid}, 64'd0);

        // Mid-cycle reset while FULL discards both words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        tick();
        in_data = 64'h6;
        tick();
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        tick();
        reset    = 1'b1;
        in_data  = 64'h77;
        in_valid = 1'b1;
        tick();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_novalid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("post_rst_data", out_data, 64'h77);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_empty", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_SKID_FLUSH_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h21;
        tick();
        in_data = 64'h22;
        tick();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h23;
        tick();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_keep", out_data, 64'h21);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_stay", {63'd0, out_valid}, 64'd0);
`endif

        // Randomized traffic against a queue model, starting EMPTY
        q.delete();
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            m_push    = in_valid && (q.size() < 2);
            m_pop     = out_ready && (q.size() > 0);
            prev_hold = (q.size() > 0) && !out_ready;
            prev_data = out_data;
            tick();
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(in_data);
            chk("rnd_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("rnd_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) chk("rnd_data", out_data, q[0]);
            if (prev_hold) chk("rnd_stable", out_data, prev_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
